// File: rtl/mem_io_bridge_if.sv
// Core-side memory bus plus data-RAM port seen by the memory/IO bridge.
interface mem_io_bridge_if;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_dout;
  logic [31:0] ram_din;

  // Bridge view: takes core requests and RAM read data.
  modport slave (
    input  mem_ren, mem_wen, mem_addr, mem_dout, ram_din,
    output mem_din, ram_ren, ram_wen, ram_addr, ram_dout
  );

  // Environment view: the core plus the RAM model.
  modport master (
    output mem_ren, mem_wen, mem_addr, mem_dout, ram_din,
    input  mem_din, ram_ren, ram_wen, ram_addr, ram_dout
  );
endinterface

// File: rtl/mem_io_bridge.sv
// Memory/IO bridge: routes core accesses to the data RAM or to a small bank of
// IO registers (LED, synchronized switches, cycle counter, countdown timer).
module mem_io_bridge #(
  parameter logic [3:0]  IO_BASE  = 4'hF,
  parameter int unsigned IO_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  mem_io_bridge_if.slave      bus,
  output logic [IO_WIDTH-1:0] led,
  input  logic [IO_WIDTH-1:0] sw,
  output logic                timer_irq
);

  localparam logic [5:0] OffLed   = 6'h00;
  localparam logic [5:0] OffSw    = 6'h01;
  localparam logic [5:0] OffCycle = 6'h02;
  localparam logic [5:0] OffTload = 6'h03;
  localparam logic [5:0] OffTcnt  = 6'h04;
  localparam logic [5:0] OffTctrl = 6'h05;

  logic                io_sel;
  logic [5:0]          io_off;
  logic                io_wr;
  logic [31:0]         io_rdata;

  logic [IO_WIDTH-1:0] led_q;
  logic [IO_WIDTH-1:0] sw_meta_q;
  logic [IO_WIDTH-1:0] sw_sync_q;
  logic [31:0]         cycle_q;
  logic [31:0]         tload_q;
  logic [31:0]         tcnt_q, tcnt_d;
  logic                en_q, auto_q;
  logic                exp_q, exp_d;
  logic                expire;

  assign io_sel = (bus.mem_addr[31:28] == IO_BASE);
  assign io_off = bus.mem_addr[7:2];
  // Reads have no side effects, so a write enable alone decides an IO write.
  assign io_wr  = bus.mem_wen & io_sel;

  assign bus.ram_ren  = bus.mem_ren & ~io_sel;
  assign bus.ram_wen  = bus.mem_wen & ~io_sel;
  assign bus.ram_addr = bus.mem_addr;
  assign bus.ram_dout = bus.mem_dout;
  assign bus.mem_din  = io_sel ? io_rdata : bus.ram_din;

  assign led       = led_q;
  assign timer_irq = exp_q & en_q;

  // IO register read mux; unmapped offsets read as zero.
  always_comb begin
    io_rdata = '0;
    unique case (io_off)
      OffLed:   io_rdata[IO_WIDTH-1:0] = led_q;
      OffSw:    io_rdata[IO_WIDTH-1:0] = sw_sync_q;
      OffCycle: io_rdata = cycle_q;
      OffTload: io_rdata = tload_q;
      OffTcnt:  io_rdata = tcnt_q;
      OffTctrl: io_rdata = {29'd0, exp_q, auto_q, en_q};
      default:  io_rdata = '0;
    endcase
  end

  // Timer next state: a TLOAD write beats counting, an expiry beats an EXP clear.
  always_comb begin
    expire = en_q && (tcnt_q == 32'd1);
    tcnt_d = tcnt_q;
    if (en_q && (tcnt_q != 32'd0)) begin
      tcnt_d = expire ? (auto_q ? tload_q : 32'd0) : tcnt_q - 32'd1;
    end
    if (io_wr && (io_off == OffTload)) begin
      tcnt_d = bus.mem_dout;
    end
    exp_d = exp_q;
    if (io_wr && (io_off == OffTctrl) && bus.mem_dout[2]) begin
      exp_d = 1'b0;
    end
    if (expire) begin
      exp_d = 1'b1;
    end
  end

  // IO register state, switch synchronizer and cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      cycle_q   <= '0;
      tload_q   <= '0;
      tcnt_q    <= '0;
      en_q      <= 1'b0;
      auto_q    <= 1'b0;
      exp_q     <= 1'b0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      tcnt_q    <= tcnt_d;
      exp_q     <= exp_d;
      if (io_wr && (io_off == OffCycle)) begin
        cycle_q <= '0;
      end else begin
        cycle_q <= cycle_q + 32'd1;
      end
      if (io_wr && (io_off == OffLed)) begin
        led_q <= bus.mem_dout[IO_WIDTH-1:0];
      end
      if (io_wr && (io_off == OffTload)) begin
        tload_q <= bus.mem_dout;
      end
      if (io_wr && (io_off == OffTctrl)) begin
        en_q   <= bus.mem_dout[0];
        auto_q <= bus.mem_dout[1];
      end
    end
  end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Bench for mem_io_bridge: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a register-level model.
module tb_mem_io_bridge;
  localparam int IOW = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [IOW-1:0] led;
  logic [IOW-1:0] sw;
  logic           timer_irq;

  mem_io_bridge_if bus ();

  mem_io_bridge #(
    .IO_BASE  (4'hF),
    .IO_WIDTH (IOW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .led       (led),
    .sw        (sw),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: the architectural registers as the programmer sees them.
  logic [IOW-1:0] m_led, m_s1, m_s2;
  logic [31:0]    m_cyc, m_tload, m_tcnt;
  logic           m_en, m_auto, m_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_led = '0; m_s1 = '0; m_s2 = '0; m_cyc = '0; m_tload = '0; m_tcnt = '0;
    m_en = 1'b0; m_auto = 1'b0; m_exp = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [5:0] off);
    case (off)
      6'd0:    return {16'd0, m_led};
      6'd1:    return {16'd0, m_s2};
      6'd2:    return m_cyc;
      6'd3:    return m_tload;
      6'd4:    return m_tcnt;
      6'd5:    return {29'd0, m_exp, m_auto, m_en};
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    logic        wr;
    logic [5:0]  off;
    logic [31:0] d;
    logic        fired;
    logic [31:0] cnt;
    if (rst) begin
      model_reset();
      return;
    end
    wr    = bus.mem_wen && (bus.mem_addr[31:28] == 4'hF);
    off   = bus.mem_addr[7:2];
    d     = bus.mem_dout;
    fired = m_en && (m_tcnt == 1);
    cnt   = m_tcnt;
    if (m_en && m_tcnt != 0) cnt = fired ? (m_auto ? m_tload : 0) : m_tcnt - 1;
    if (wr && off == 6'd3) begin
      cnt     = d;
      m_tload = d;
    end
    m_tcnt = cnt;
    if (wr && off == 6'd5 && d[2]) m_exp = 1'b0;
    if (fired) m_exp = 1'b1;
    if (wr && off == 6'd5) begin
      m_en   = d[0];
      m_auto = d[1];
    end
    m_cyc = (wr && off == 6'd2) ? 32'd0 : m_cyc + 1;
    if (wr && off == 6'd0) m_led = d[IOW-1:0];
    m_s2 = m_s1;
    m_s1 = sw;
  endtask

  // Every-cycle comparison of all DUT outputs against the model.
  task automatic check_now();
    logic io;
    io = (bus.mem_addr[31:28] == 4'hF);
    chk("ram_ren", 32'(bus.ram_ren), 32'(bus.mem_ren & ~io));
    chk("ram_wen", 32'(bus.ram_wen), 32'(bus.mem_wen & ~io));
    chk("ram_addr", bus.ram_addr, bus.mem_addr);
    chk("ram_dout", bus.ram_dout, bus.mem_dout);
    chk("mem_din", bus.mem_din, io ? model_read(bus.mem_addr[7:2]) : bus.ram_din);
    chk("led", 32'(led), 32'(m_led));
    chk("timer_irq", 32'(timer_irq), 32'(m_exp & m_en));
  endtask

  // Inputs are applied just after a negedge; check, clock, advance the model.
  task automatic cycle();
    #1 check_now();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic ren, input logic wen, input logic [31:0] addr,
                       input logic [31:0] dout);
    bus.mem_ren  = ren;
    bus.mem_wen  = wen;
    bus.mem_addr = addr;
    bus.mem_dout = dout;
  endtask

  task automatic io_wr(input logic [7:0] off, input logic [31:0] data);
    drive(1'b0, 1'b1, {24'hF00000, off}, data);
    cycle();
  endtask

  task automatic io_rd_chk(input string name, input logic [7:0] off, input logic [31:0] exp);
    drive(1'b1, 1'b0, {24'hF00000, off}, 32'd0);
    #1 chk(name, bus.mem_din, exp);
    cycle();
  endtask

  initial begin
    rst = 1'b1;
    sw  = '0;
    bus.ram_din = '0;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    chk("reset led", 32'(led), 32'd0);
    chk("reset irq", 32'(timer_irq), 32'd0);

    // RAM pass-through
    drive(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    #1;
    chk("ram wr wen", 32'(bus.ram_wen), 32'd1);
    chk("ram wr addr", bus.ram_addr, 32'h10);
    chk("ram wr data", bus.ram_dout, 32'hDEAD_BEEF);
    cycle();
    chk("ram wr led", 32'(led), 32'd0);
    bus.ram_din = 32'h1234;
    drive(1'b1, 1'b0, 32'h0000_0010, 32'd0);
    #1;
    chk("ram rd din", bus.mem_din, 32'h1234);
    chk("ram rd ren", 32'(bus.ram_ren), 32'd1);
    cycle();

    // LED and synchronized switches
    io_wr(8'h00, 32'h0001_A5A5);
    chk("led write", 32'(led), 32'hA5A5);
    io_rd_chk("led read", 8'h00, 32'hA5A5);
    sw = 16'h00FF;
    io_rd_chk("sw edge0", 8'h04, 32'h0);
    io_rd_chk("sw edge1", 8'h04, 32'h0);
    io_rd_chk("sw edge2", 8'h04, 32'hFF);

    // One-shot timer
    io_wr(8'h0C, 32'd3);
    io_wr(8'h14, 32'h1);
    io_rd_chk("tcnt 3", 8'h10, 32'd3);
    io_rd_chk("tcnt 2", 8'h10, 32'd2);
    chk("irq before", 32'(timer_irq), 32'd0);
    io_rd_chk("tcnt 1", 8'h10, 32'd1);
    chk("irq at zero", 32'(timer_irq), 32'd1);
    io_rd_chk("tctrl exp", 8'h14, 32'h5);
    io_rd_chk("tcnt stays 0", 8'h10, 32'd0);
    io_rd_chk("tcnt still 0", 8'h10, 32'd0);
    io_wr(8'h14, 32'h4);
    io_rd_chk("exp cleared", 8'h14, 32'h0);

    // Auto-reload with clear colliding on the expiry edge
    io_wr(8'h0C, 32'd2);
    io_wr(8'h14, 32'h3);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    cycle();
    io_wr(8'h14, 32'h7);
    io_rd_chk("auto reload", 8'h10, 32'd2);
    io_rd_chk("auto exp kept", 8'h14, 32'h7);
    io_wr(8'h14, 32'h7);
    io_rd_chk("auto exp clr", 8'h14, 32'h3);

    // Cycle counter clear
    io_wr(8'h08, 32'h0001_2345);
    io_rd_chk("cycle clr", 8'h08, 32'd0);
    io_rd_chk("cycle inc", 8'h08, 32'd1);

    // Reset mid-countdown
    io_wr(8'h0C, 32'd5);
    io_wr(8'h14, 32'h1);
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    cycle();
    rst = 1'b0;
    chk("rst led", 32'(led), 32'd0);
    chk("rst irq", 32'(timer_irq), 32'd0);
    io_rd_chk("rst tcnt", 8'h10, 32'd0);
    io_rd_chk("rst tload", 8'h0C, 32'd0);
    io_rd_chk("rst cycle", 8'h08, 32'd2);
    repeat (6) io_rd_chk("rst no exp", 8'h14, 32'd0);
    chk("rst irq later", 32'(timer_irq), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic [5:0]  off;
      logic [31:0] addr;
      logic [31:0] data;
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 15) == 0) sw = 16'($urandom);
      bus.ram_din = $urandom;
      off  = ($urandom_range(0, 9) < 8) ? 6'($urandom_range(0, 7)) : 6'($urandom);
      addr = ($urandom_range(0, 3) != 0) ? {4'hF, 20'($urandom), off, 2'($urandom)}
                                         : $urandom;
      data = $urandom;
      if (off == 6'd3) data = $urandom_range(0, 6);
      if (off == 6'd2 && $urandom_range(0, 3) != 0) data = 32'd0;
      drive(1'($urandom), ($urandom_range(0, 9) < 3), addr, data);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_io_bridge.md
MEM_IO_BRIDGE -- requirements
Module: mem_io_bridge

Interface
REQ-001 SHALL have parameter IO_BASE, default 4'hF, which is the mem_addr[31:28] value that selects the IO region.
REQ-002 SHALL have parameter IO_WIDTH, default 16, which is the width of led and sw.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have ports mem_ren, mem_wen (input, 1 bit each): core read/write enables.
REQ-006 SHALL have port mem_addr, input, 32 bits: core address.
REQ-007 SHALL have port mem_dout, input, 32 bits: core write data.
REQ-008 SHALL have port mem_din, output, 32 bits: read data returned to the core.
REQ-009 SHALL have ports ram_ren, ram_wen (output, 1 bit each), ram_addr (output, 32 bits), ram_dout (output, 32 bits) and ram_din (input, 32 bits): data RAM port.
REQ-010 SHALL have ports led (output, IO_WIDTH bits), sw (input, IO_WIDTH bits, asynchronous) and timer_irq (output, 1 bit).

Function
REQ-011 SHALL decode io_sel = (mem_addr[31:28] == IO_BASE) combinationally; otherwise the access is a RAM access.
REQ-012 SHALL drive ram_ren = mem_ren & ~io_sel, ram_wen = mem_wen & ~io_sel, ram_addr = mem_addr and ram_dout = mem_dout, all combinationally.
REQ-013 SHALL drive mem_din = io_sel ? io_rdata : ram_din, combinationally, with zero added latency.
REQ-014 SHALL use mem_addr[7:2] as the IO register offset, with mem_addr[27:8] and [1:0] ignored, and the following map.
  - 0x00 LED: RW; low IO_WIDTH bits drive led; read zero-extended.
  - 0x04 SW: RO; the sw value after a 2-flop synchronizer.
  - 0x08 CYCLE: 32-bit free-running counter, +1 every cycle, wraps at 2^32; any write clears it to 0.
  - 0x0C TLOAD: RW 32 bits; a write sets both TLOAD and TCNT to mem_dout.
  - 0x10 TCNT: RO current timer count.
  - 0x14 TCTRL: bit0 EN (RW), bit1 AUTO (RW), bit2 EXP (read; writing 1 clears, W1C); other bits read 0.
  - Any other offset: reads return 0; writes are ignored.
REQ-015 IO writes SHALL occur when mem_wen & io_sel, at the clock edge; mem_ren is ignored for IO since reads are side-effect free.
REQ-016 When EN=1 and TCNT!=0, TCNT SHALL decrement by 1 per cycle.
REQ-017 When EN=1 and TCNT==1, EXP SHALL set on that edge, and TCNT SHALL become TLOAD if AUTO=1, else 0.
REQ-018 When TCNT==0 with AUTO=0, the timer SHALL stay idle; EXP SHALL not re-set.
REQ-019 A TLOAD write in the same cycle as a decrement or reload SHALL win.
REQ-020 An EXP W1C clear in the same cycle as an expiry event SHALL lose: EXP stays 1.
REQ-021 A CYCLE write SHALL take priority over the increment, giving value 0 after that edge.
REQ-022 timer_irq SHALL equal EXP & EN, registered-state derived with no extra delay.
REQ-023 mem_ren and mem_wen both high SHALL be treated as a write for IO; for RAM, both are forwarded unchanged.

Reset
REQ-024 On rst=1 at a clock edge, LED, CYCLE, TLOAD, TCNT, EN, AUTO, EXP and both synchronizer stages SHALL clear to 0.
REQ-025 After reset, led=0 and timer_irq=0; mem_din and the ram_* outputs stay combinational from their inputs.
REQ-026 rst SHALL take priority over any simultaneous write or count event, including mid-countdown.

Verification
REQ-027 RAM pass-through: write addr 0x0000_0010 data 0xDEADBEEF -> ram_wen=1 with same addr/data, led unchanged; with ram_din=0x1234 and addr 0x10 read -> mem_din=0x1234, ram_ren=1.
REQ-028 LED/SW: write 0xF000_0000 data 0x0001_A5A5 -> led=0xA5A5 next cycle; sw=0x00FF -> read 0xF000_0004 returns 0x00FF by the 2nd edge after the change, not before.
REQ-029 One-shot timer: TLOAD=3, TCTRL=0x1 -> TCNT 3,2,1,0 on successive edges; EXP=1 and timer_irq=1 on the edge TCNT hits 0; TCNT stays 0.
REQ-030 Auto-reload with clear collision: TLOAD=2, TCTRL=0x3, then write TCTRL=0x7 on the expiry cycle -> EXP remains 1, TCNT=2; a later write of 0x7 clears EXP.
REQ-031 CYCLE wrap/clear: force CYCLE to 0xFFFF_FFFF -> next read 0; a write in any cycle -> 0 the next cycle.
REQ-032 Reset mid-count: TCNT=5 with EN=1, assert rst one cycle -> all registers 0, timer_irq=0, no EXP set afterwards.
